deleted_node_streamer: RTL

DELETED_NODE_STREAMER -- requirements
Module: deleted_node_streamer

---
 rtl/deleted_node_streamer_pkg.sv | 18 +
 rtl/deleted_node_streamer_store.sv | 35 +++
 rtl/deleted_node_streamer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/deleted_node_streamer_pkg.sv
// Shared types and sizing helpers for the deleted-node streamer.
package deleted_node_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deleted_node_streamer_store.sv
// Register array of deleted node IDs: one write port, one combinational indexed read port.
module deleted_node_store
  import deleted_node_streamer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Empty slots read as all-ones so a stale read is easy to spot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '1;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/deleted_node_streamer.sv
// Records deleted node IDs, then streams them out in write order over a valid/ready port.
module deleted_node_streamer
  import deleted_node_streamer_pkg::*;
#(
  parameter int max_deletions = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int CW            = count_width(max_deletions),
  parameter int AW            = addr_width(max_deletions)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add,
  input  logic                  conn,
  input  logic [DATA_WIDTH-1:0] node_id,
  input  logic                  start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_node_id,
  output logic                  done,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  overflow
);

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rd_idx_q, rd_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_node_id_q, out_node_id_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  logic                  full_s;
  logic                  wr_en_s;
  logic [AW-1:0]         rd_addr_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  assign full_s = (count_q == CW'(max_deletions));

  deleted_node_store #(
    .DEPTH      (max_deletions),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_idx  (count_q[AW-1:0]),
    .wr_data (node_id),
    .rd_idx  (rd_addr_s),
    .rd_data (rd_data_s)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rd_idx_d      = rd_idx_q;
    out_valid_d   = out_valid_q;
    out_node_id_d = out_node_id_q;
    done_d        = 1'b0;
    overflow_d    = overflow_q;
    wr_en_s       = 1'b0;
    rd_addr_s     = rd_idx_q + AW'(1);
    case (state_q)
      IDLE: begin
        rd_addr_s = '0;
        if (add && !conn) begin
          if (!full_s) begin
            wr_en_s = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          count_d = count_q;
        end
        // A same-cycle write into an empty store must bypass straight to the output.
        if (start) begin
          rd_idx_d = '0;
          if (count_d != '0) begin
            state_d       = STREAM;
            out_valid_d   = 1'b1;
            out_node_id_d = (count_q == '0) ? node_id : rd_data_s;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (CW'(rd_idx_q) == count_q - CW'(1)) begin
            state_d     = FINISH;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            rd_idx_d      = rd_idx_q + AW'(1);
            out_node_id_d = rd_data_s;
          end
        end else begin
          state_d = STREAM;
        end
      end
      FINISH: begin
        state_d    = IDLE;
        count_d    = '0;
        overflow_d = 1'b0;
        rd_idx_d   = '0;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      rd_idx_q      <= '0;
      out_valid_q   <= 1'b0;
      out_node_id_q <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rd_idx_q      <= rd_idx_d;
      out_valid_q   <= out_valid_d;
      out_node_id_q <= out_node_id_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_node_id = out_node_id_q;
  assign done        = done_q;
  assign count       = count_q;
  assign full        = full_s;
  assign overflow    = overflow_q;

endmodule
